// File: rtl/operand_fetch.sv
// Operand fetch: 8x width register file, sequential A/B read over one port, 1-bit shifter on B.
// Latency: op_valid two edges after an accepted start; operands held until op_ack, start ignored while reading.
module operand_fetch #(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [2:0]       rn,
  input  logic [2:0]       rm,
  input  logic [1:0]       shift,
  input  logic             op_ack,
  input  logic             wb_en,
  input  logic [2:0]       wb_addr,
  input  logic [width-1:0] wb_data,
  output logic [width-1:0] Ain,
  output logic [width-1:0] Bin,
  output logic             op_valid,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ_A = 2'd1,
    READ_B = 2'd2,
    VALID  = 2'd3
  } state_t;

  typedef struct packed {
    logic [2:0] rn;
    logic [2:0] rm;
    logic [1:0] shift;
  } cmd_t;

  state_t           state;
  cmd_t             cmd_q;
  logic [width-1:0] rf [8];

  logic [2:0]       rd_addr;
  logic [width-1:0] rd_dat;
  logic [width-1:0] shifted;
  logic             accept;

  // Single read port: B's register is only addressed during READ_B.
  always_comb begin
    rd_addr = (state == READ_B) ? cmd_q.rm : cmd_q.rn;
    rd_dat  = (wb_en && (wb_addr == rd_addr)) ? wb_data : rf[rd_addr];
  end

  always_comb begin
    shifted = rd_dat;
    case (cmd_q.shift)
      2'b01:   shifted = {rd_dat[width-2:0], 1'b0};
      2'b10:   shifted = {1'b0, rd_dat[width-1:1]};
      2'b11:   shifted = {rd_dat[width-1], rd_dat[width-1:1]};
      default: shifted = rd_dat;
    endcase
  end

  assign accept = start && ((state == IDLE) || ((state == VALID) && op_ack));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      cmd_q    <= '0;
      Ain      <= '0;
      Bin      <= '0;
      op_valid <= 1'b0;
      busy     <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        rf[i] <= '0;
      end
    end else begin
      if (wb_en) begin
        rf[wb_addr] <= wb_data;
      end
      if (accept) begin
        cmd_q <= {rn, rm, shift};
      end
      case (state)
        IDLE: begin
          if (start) begin
            state <= READ_A;
            busy  <= 1'b1;
          end
        end
        READ_A: begin
          Ain   <= rd_dat;
          state <= READ_B;
        end
        READ_B: begin
          Bin      <= shifted;
          op_valid <= 1'b1;
          state    <= VALID;
        end
        VALID: begin
          if (op_ack) begin
            op_valid <= 1'b0;
            if (start) begin
              state <= READ_A;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state    <= IDLE;
          op_valid <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios plus random traffic against a cycle-level reference model.
module tb_operand_fetch;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         resetn, start, op_ack, wb_en;
  logic [2:0]   rn, rm, wb_addr;
  logic [1:0]   shift;
  logic [W-1:0] wb_data;
  logic [W-1:0] Ain, Bin;
  logic         op_valid, busy;

  always #5 clk = ~clk;

  operand_fetch #(.width(W)) dut (
    .clk(clk), .resetn(resetn), .start(start), .rn(rn), .rm(rm), .shift(shift),
    .op_ack(op_ack), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .Ain(Ain), .Bin(Bin), .op_valid(op_valid), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: age = -1 idle, else edges since the command was accepted (saturating at 2 = valid).
  logic [W-1:0] m_rf [8];
  int           m_age;
  logic [2:0]   m_rn, m_rm;
  logic [1:0]   m_sh;
  logic [W-1:0] m_a, m_b;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] m_read(input logic [2:0] a);
    if (wb_en && wb_addr == a) return wb_data;
    return m_rf[a];
  endfunction

  function automatic logic [W-1:0] m_shift(input logic [W-1:0] x, input logic [1:0] s);
    int unsigned v;
    int unsigned top;
    v   = x;
    top = 1 << (W - 1);
    case (s)
      2'd1:    return W'((v * 2) % (top * 2));
      2'd2:    return W'(v / 2);
      2'd3:    return W'(v / 2 + (v & top));
      default: return x;
    endcase
  endfunction

  // Advance the model with the inputs of this cycle, take the edge, compare on the falling edge.
  task automatic step();
    if (!resetn) begin
      for (int i = 0; i < 8; i++) m_rf[i] = '0;
      m_age = -1; m_rn = 0; m_rm = 0; m_sh = 0; m_a = '0; m_b = '0;
    end else begin
      logic [W-1:0] na, nb;
      int nage;
      na = m_a; nb = m_b; nage = m_age;
      if (m_age == 0) begin
        na = m_read(m_rn); nage = 1;
      end else if (m_age == 1) begin
        nb = m_shift(m_read(m_rm), m_sh); nage = 2;
      end else if (m_age == 2 && op_ack) begin
        nage = start ? 0 : -1;
      end else if (m_age == -1 && start) begin
        nage = 0;
      end
      if (start && (m_age == -1 || (m_age == 2 && op_ack))) begin
        m_rn = rn; m_rm = rm; m_sh = shift;
      end
      if (wb_en) m_rf[wb_addr] = wb_data;
      m_a = na; m_b = nb; m_age = nage;
    end
    @(posedge clk);
    @(negedge clk);
    chk("op_valid", W'(op_valid), W'(m_age == 2));
    chk("busy", W'(busy), W'(m_age != -1));
    chk("Ain", Ain, m_a);
    chk("Bin", Bin, m_b);
  endtask

  task automatic neutral();
    resetn = 1; start = 0; op_ack = 0; wb_en = 0;
    rn = 0; rm = 0; shift = 0; wb_addr = 0; wb_data = '0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [W-1:0] d);
    wb_en = 1; wb_addr = a; wb_data = d;
    step();
    wb_en = 0;
  endtask

  task automatic fetch(input logic [2:0] a, input logic [2:0] b, input logic [1:0] s);
    rn = a; rm = b; shift = s; start = 1;
    step();
    start = 0;
    step();
    step();
  endtask

  task automatic ack();
    op_ack = 1;
    step();
    op_ack = 0;
  endtask

  task automatic check_all_zero();
    for (int i = 0; i < 8; i++) begin
      fetch(3'(i), 3'(i), 2'd0);
      chk("zero_reg_A", Ain, 16'h0000);
      chk("zero_reg_B", Bin, 16'h0000);
      ack();
    end
  endtask

  logic [W-1:0] shexp [4];

  initial begin
    neutral();
    // Reset with start and write asserted: both overridden.
    resetn = 0; start = 1; wb_en = 1; wb_addr = 3; wb_data = 16'hFFFF;
    step();
    neutral();
    chk("rst_op_valid", W'(op_valid), 16'h0);
    chk("rst_busy", W'(busy), 16'h0);
    chk("rst_Ain", Ain, 16'h0000);
    chk("rst_Bin", Bin, 16'h0000);
    check_all_zero();

    // Basic fetch and latency.
    wr(3'd2, 16'h0005);
    wr(3'd3, 16'h0003);
    rn = 2; rm = 3; shift = 0; start = 1;
    step();
    start = 0;
    chk("lat_k", W'(op_valid), 16'h0);
    step();
    chk("lat_k1", W'(op_valid), 16'h0);
    step();
    chk("lat_k2", W'(op_valid), 16'h1);
    chk("basic_A", Ain, 16'h0005);
    chk("basic_B", Bin, 16'h0003);
    ack();

    // Shifter codes.
    shexp[0] = 16'h8001; shexp[1] = 16'h0002; shexp[2] = 16'h4000; shexp[3] = 16'hC000;
    wr(3'd3, 16'h8001);
    for (int s = 0; s < 4; s++) begin
      fetch(3'd0, 3'd3, 2'(s));
      chk("shift_B", Bin, shexp[s]);
      ack();
    end

    // Bypass during READ_B.
    wr(3'd3, 16'h0011);
    rn = 0; rm = 3; shift = 0; start = 1;
    step();
    start = 0;
    step();
    wb_en = 1; wb_addr = 3; wb_data = 16'h00AA;
    step();
    wb_en = 0;
    chk("bypass_B", Bin, 16'h00AA);
    ack();

    // Write in VALID leaves latched operand alone.
    wr(3'd3, 16'h0011);
    fetch(3'd0, 3'd3, 2'd0);
    wr(3'd3, 16'h00BB);
    chk("late_wr_B", Bin, 16'h0011);
    ack();

    // Hold for 5 cycles, then back-to-back with a start pulse in READ_A.
    wr(3'd2, 16'h1234);
    wr(3'd3, 16'h0F0F);
    fetch(3'd2, 3'd3, 2'd0);
    for (int i = 0; i < 5; i++) step();
    chk("hold_A", Ain, 16'h1234);
    chk("hold_B", Bin, 16'h0F0F);
    chk("hold_valid", W'(op_valid), 16'h1);
    op_ack = 1; start = 1; rn = 3; rm = 2;
    step();
    op_ack = 0; start = 1; rn = 7; rm = 7;
    chk("b2b_gap1", W'(op_valid), 16'h0);
    step();
    start = 0;
    chk("b2b_gap2", W'(op_valid), 16'h0);
    step();
    chk("b2b_valid", W'(op_valid), 16'h1);
    chk("b2b_A", Ain, 16'h0F0F);
    chk("b2b_B", Bin, 16'h1234);
    ack();
    chk("ignored_start_idle", W'(busy), 16'h0);

    // Reset during READ_B.
    wr(3'd5, 16'h5555);
    rn = 5; rm = 5; start = 1;
    step();
    start = 0;
    step();
    resetn = 0;
    step();
    resetn = 1;
    chk("midrst_busy", W'(busy), 16'h0);
    chk("midrst_valid", W'(op_valid), 16'h0);
    chk("midrst_B", Bin, 16'h0000);
    check_all_zero();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      resetn  = ($urandom_range(0, 199) != 0);
      start   = $urandom_range(0, 1);
      op_ack  = ($urandom_range(0, 2) != 0);
      rn      = 3'($urandom_range(0, 7));
      rm      = 3'($urandom_range(0, 7));
      shift   = 2'($urandom_range(0, 3));
      wb_en   = $urandom_range(0, 1);
      wb_addr = 3'($urandom_range(0, 7));
      wb_data = W'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
